// File: rtl/exec_sequencer.sv
// Multi-cycle control FSM for the single-issue core: owns PC, fetch handshake and
// instruction register, and gates register-file writes and LSU requests per state.
module exec_sequencer #(
  parameter int                    ADDR_WIDTH = 32,
  parameter int                    WORD_WIDTH = 32,
  parameter logic [ADDR_WIDTH-1:0] BOOT_ADDR  = '0
) (
  input  logic                  clk,
  input  logic                  rst_n,
  output logic                  instr_req_o,
  output logic [ADDR_WIDTH-1:0] instr_addr_o,
  input  logic                  instr_gnt_i,
  input  logic                  instr_rvalid_i,
  input  logic [WORD_WIDTH-1:0] instr_rdata_i,
  output logic [WORD_WIDTH-1:0] instr_o,
  output logic [ADDR_WIDTH-1:0] pc_o,
  output logic                  cycle_counter_o,
  input  logic                  jump_inst_i,
  input  logic                  branch_inst_i,
  input  logic                  illegal_inst_i,
  input  logic                  compressed_inst_i,
  input  logic                  lsu_r_en_i,
  input  logic                  lsu_w_en_i,
  input  logic                  rf_we_i,
  output logic                  rf_we_o,
  input  logic [WORD_WIDTH-1:0] alu_result_i,
  output logic                  lsu_req_o,
  input  logic                  lsu_done_i,
  output logic                  halt_o
);

  localparam logic [2:0] S_FETCH = 3'd0;
  localparam logic [2:0] S_WAIT  = 3'd1;
  localparam logic [2:0] S_EXEC0 = 3'd2;
  localparam logic [2:0] S_EXEC1 = 3'd3;
  localparam logic [2:0] S_LSU   = 3'd4;
  localparam logic [2:0] S_HALT  = 3'd5;

  localparam logic [WORD_WIDTH-1:0] NOP = WORD_WIDTH'(32'h0000_0013);

  logic [2:0]            state_q, state_d;
  logic [ADDR_WIDTH-1:0] pc_q, pc_d, pc_inc;
  logic [WORD_WIDTH-1:0] instr_q, instr_d;
  logic                  we_gate, lsu_req;

  assign pc_inc = pc_q + (compressed_inst_i ? ADDR_WIDTH'(2) : ADDR_WIDTH'(4));

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    instr_d = instr_q;
    we_gate = 1'b0;
    lsu_req = 1'b0;
    case (state_q)
      S_FETCH: if (instr_gnt_i) state_d = S_WAIT;
      S_WAIT: begin
        // a same-cycle rvalid in FETCH is dropped; data is only taken here
        if (instr_rvalid_i) begin
          instr_d = instr_rdata_i;
          state_d = S_EXEC0;
        end
      end
      S_EXEC0: begin
        if (illegal_inst_i) begin
          state_d = S_HALT;
        end else if (jump_inst_i) begin
          we_gate = 1'b1;
          state_d = S_EXEC1;
        end else if (branch_inst_i) begin
          if (alu_result_i[0]) begin
            state_d = S_EXEC1;
          end else begin
            pc_d    = pc_inc;
            state_d = S_FETCH;
          end
        end else if (lsu_r_en_i || lsu_w_en_i) begin
          lsu_req = 1'b1;
          state_d = S_LSU;
        end else begin
          we_gate = 1'b1;
          pc_d    = pc_inc;
          state_d = S_FETCH;
        end
      end
      S_EXEC1: begin
        pc_d    = {alu_result_i[ADDR_WIDTH-1:1], 1'b0};
        state_d = S_FETCH;
      end
      S_LSU: begin
        if (lsu_done_i) begin
          we_gate = 1'b1;
          pc_d    = pc_inc;
          state_d = S_FETCH;
        end else begin
          lsu_req = 1'b1;
        end
      end
      S_HALT:  state_d = S_HALT;
      default: state_d = S_FETCH;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_FETCH;
      pc_q    <= BOOT_ADDR;
      instr_q <= NOP;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      instr_q <= instr_d;
    end
  end

  // reset parks the FSM in FETCH, so the request is masked while reset is held
  assign instr_req_o     = rst_n & (state_q == S_FETCH);
  assign instr_addr_o    = pc_q;
  assign pc_o            = pc_q;
  assign instr_o         = instr_q;
  assign cycle_counter_o = (state_q == S_EXEC1);
  assign rf_we_o         = rf_we_i & we_gate;
  assign lsu_req_o       = lsu_req;
  assign halt_o          = (state_q == S_HALT);

endmodule
